serial_subtractor_ctrl: RTL and testbench
=========================================

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-004 SHALL have port in_valid, input, 1: operands a/b presented.
REQ-005 SHALL have port in_ready, output, 1: controller can accept operands.
REQ-006 SHALL have port a, input, WIDTH: minuend.
REQ-007 SHALL have port b, input, WIDTH: subtrahend.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes result.
REQ-010 SHALL have port diff, output, WIDTH: a - b modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out, output, 1: final borrow, 1 iff a < b unsigned.
REQ-012 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-015 On in_valid & in_ready, SHALL latch a and b, clear the borrow flop, clear the bit counter, and enter RUN.
REQ-016 Each RUN cycle SHALL process one bit, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-017 Each RUN cycle SHALL shift d into the diff register from the MSB side and shift the operand registers right by one.
REQ-018 After exactly WIDTH RUN cycles, SHALL enter DONE with diff complete and borrow_out = final br.
REQ-019 Latency: if acceptance occurs at the edge ending cycle 0, out_valid SHALL first be high in cycle WIDTH+1.
REQ-020 In DONE, out_valid SHALL be 1, and diff and borrow_out SHALL stay stable until out_valid & out_ready.
REQ-021 On out_valid & out_ready, SHALL return to IDLE; in_ready SHALL rise the next cycle, with no same-cycle restart.
REQ-022 Sustained throughput SHALL be one operation per WIDTH+2 cycles when out_ready is held at 1.
REQ-023 in_valid asserted during RUN or DONE SHALL be ignored, with no state change.
REQ-024 diff and borrow_out SHALL be meaningful only while out_valid = 1.
REQ-025 WIDTH = 1 SHALL work: one RUN cycle, out_valid in cycle 2.

Reset
REQ-026 rst = 1 at any clock edge SHALL force IDLE and clear the operand registers, diff, borrow flop, and counter.
REQ-027 Output values after reset SHALL be: in_ready = 1, out_valid = 0, diff = 0, borrow_out = 0, busy = 0.
REQ-028 Reset in the middle of RUN or DONE SHALL abort the operation; the result SHALL be discarded and never presented.
REQ-029 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-030 Macro SERSUB_ZERO_FLAG_EN defined: SHALL add output port zero (1 bit), equal to (diff == 0) while out_valid = 1, else 0; reset value 0.
REQ-031 Macro SERSUB_ZERO_FLAG_EN undefined: port zero and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH = 8)
REQ-032 a = 0x05, b = 0x03 accepted in cycle 0 -> out_valid in cycle 9, diff = 0x02, borrow_out = 0.
REQ-033 a = 0x03, b = 0x05 -> diff = 0xFE, borrow_out = 1; a = 0x00, b = 0xFF -> diff = 0x01, borrow_out = 1.
REQ-034 a = 0xAA, b = 0xAA -> diff = 0x00, borrow_out = 0, and zero = 1 when SERSUB_ZERO_FLAG_EN is defined.
REQ-035 out_ready held 0 for 5 cycles in DONE, with a new in_valid pulse -> diff, borrow_out, and out_valid stable; in_ready = 0; the pulse is ignored.
REQ-036 rst asserted during the 4th RUN cycle -> next cycle state IDLE, in_ready = 1, out_valid = 0, diff = 0; no stale result ever appears.
REQ-037 out_ready tied 1 with 4 back-to-back random operations -> acceptances exactly 10 cycles apart, and every result matches the reference model.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor with valid/ready handshakes: one result bit per RUN cycle, LSB first.
// Define SERSUB_ZERO_FLAG_EN to add the registered 'zero' result flag output.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
`ifdef SERSUB_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             br_q;
    logic             br_d;
    logic             d_bit;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
`ifdef SERSUB_ZERO_FLAG_EN
    logic             zero_q;
`endif

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    function automatic logic [WIDTH-1:0] shift_in_msb(input logic msb, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v >> 1;
        r[WIDTH-1] = msb;
        return r;
    endfunction

    always_comb begin
        d_bit  = a_q[0] ^ b_q[0] ^ br_q;
        br_d   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        diff_d = shift_in_msb(d_bit, diff_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            br_q        <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        br_q       <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    diff_q <= diff_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
`ifdef SERSUB_ZERO_FLAG_EN
                        zero_q      <= (diff_d == '0);
`endif
                    end
                end
                S_DONE: begin
                    // Result and flags hold until the consumer takes them.
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
                        zero_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
                    zero_q      <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign diff       = diff_q;
    assign borrow_out = br_q;
`ifdef SERSUB_ZERO_FLAG_EN
    assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH = 8) against a transaction-level model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         busy;
`ifdef SERSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy)
`ifdef SERSUB_ZERO_FLAG_EN
        ,
        .zero       (zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: 0 = waiting for operands, 1 = computing (WIDTH cycles), 2 = holding result.
    int           m_ph   = 0;
    int           m_left = 0;
    logic [W-1:0] m_res  = '0;
    logic         m_bor  = 1'b0;
    int           acc_cyc[$];
    bit           chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph   <= 0;
            m_left <= 0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_ph   <= 1;
                    m_left <= W;
                    m_res  <= a - b;
                    m_bor  <= (a < b);
                    acc_cyc.push_back(cyc);
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_ph <= 2;
                end
                default: if (out_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 32'(in_ready), 32'(m_ph == 0));
            chk("out_valid", 32'(out_valid), 32'(m_ph == 2));
            chk("busy", 32'(busy), 32'(m_ph != 0));
            if (m_ph == 2) begin
                chk("diff", 32'(diff), 32'(m_res));
                chk("borrow_out", 32'(borrow_out), 32'(m_bor));
            end
`ifdef SERSUB_ZERO_FLAG_EN
            chk("zero", 32'(zero), 32'((m_ph == 2) && (m_res == '0)));
`endif
        end
    end

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [W-1:0] ed, input logic eb, input int hold);
        int c0;
        bit got;
        @(posedge clk); #1;
        a = ia; b = ib; in_valid = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk("op_done", 32'(got), 32'd1);
        if (got) begin
            chk("latency", cyc - c0, W + 1);
            chk("diff_lit", 32'(diff), 32'(ed));
            chk("borrow_lit", 32'(borrow_out), 32'(eb));
`ifdef SERSUB_ZERO_FLAG_EN
            chk("zero_lit", 32'(zero), 32'(ed == '0));
`endif
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                in_valid = (i == 2);
                a = ~ia; b = ib + 1'b1;
                @(negedge clk);
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_diff", 32'(diff), 32'(ed));
                chk("hold_borrow", 32'(borrow_out), 32'(eb));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("post_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef SERSUB_ZERO_FLAG_EN
        chk("rst_zero", 32'(zero), 32'd0);
`endif
        rst = 1'b0;
        chk_en = 1'b1;

        op(8'h05, 8'h03, 8'h02, 1'b0, 0);
        op(8'h03, 8'h05, 8'hFE, 1'b1, 0);
        op(8'h00, 8'hFF, 8'h01, 1'b1, 0);
        op(8'hAA, 8'hAA, 8'h00, 1'b0, 5);
        op(8'hFF, 8'h00, 8'hFF, 1'b0, 0);
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1);

        // Abort in the 4th RUN cycle.
        @(posedge clk); #1;
        a = 8'h5C; b = 8'h21; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_borrow", 32'(borrow_out), 32'd0);
        repeat (15) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        // Back-to-back with out_ready tied high.
        @(posedge clk); #1;
        out_ready = 1'b1;
        acc_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            a = pick_operand(); b = pick_operand(); in_valid = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 30 && !got; i++) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
            end
            chk("b2b_accept", 32'(got), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("b2b_count", acc_cyc.size(), 32'd4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            chk("b2b_gap", acc_cyc[i] - acc_cyc[i-1], W + 2);
        out_ready = 1'b0;

        // Random traffic including occasional resets.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            a = pick_operand();
            b = pick_operand();
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
